uart_fifo_core: RTL

- Parametrised, full-duplex UART core; next generation of the single-byte UART top.
- Adds configurable-depth TX and RX FIFOs, a programmable baud divisor with 16x-oversampled receive, and sticky error flags.
- Adds a maskable level interrupt and a small addressed register interface.
- Self-contained: holds its own serialiser and deserialiser and sits directly on the processor I/O port.

---
 rtl/uart_fifo_core.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, 16x-oversampled receive, sticky errors and a register port.
// Define UART_LOOPBACK_EN to add ie[3], which routes tx internally back into the receiver.
module uart_fifo_core #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned DIV_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic             tx,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             irq
);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
`ifdef UART_LOOPBACK_EN
    localparam int unsigned IeW = 4;
`else
    localparam int unsigned IeW = 3;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TxAw:0]  tx_wp_q, tx_rp_q;
    logic [RxAw:0]  rx_wp_q, rx_rp_q;
    logic           tx_empty, tx_full, rx_empty, rx_full;
    logic           tx_push, tx_load, rx_evt, rx_push, rx_pop, rx_perr, stat_rd;
    logic           ovf_q, ferr_q, perr_q, irq_q, tx_idle;
    logic [IeW-1:0] ie_q;
    logic [7:0]     tx_head;

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q ^ tx_rp_q) == {1'b1, {TxAw{1'b0}}};
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q ^ rx_rp_q) == {1'b1, {RxAw{1'b0}}};
    assign tx_push  = wr_en && addr == 2'd0 && !tx_full;
    assign rx_pop   = rd_en && addr == 2'd0 && !rx_empty;
    assign stat_rd  = rd_en && addr == 2'd1;
    assign tx_head  = tx_mem[tx_rp_q[TxAw-1:0]];

    // Free-running oversample tick shared by the receiver
    logic [DIV_W-1:0] div_q;
    logic             tick;
    assign tick = div_q >= baud_div;

    // Transmitter; its own divider restarts at load so bit edges are exact
    state_e           tx_st_q;
    logic [DIV_W-1:0] tx_div_q;
    logic [3:0]       tx_tcnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_sh_q;
    logic             tx_eight_q, tx_pen_q, tx_par_q, tx_q, tx_bit_end;

    assign tx_bit_end = (tx_div_q >= baud_div) && (tx_tcnt_q == 4'd15);
    assign tx_load    = !tx_empty && (tx_st_q == StIdle || (tx_st_q == StStop && tx_bit_end));
    assign tx_idle    = tx_empty && tx_st_q == StIdle;

    // Receiver
    state_e     rx_st_q;
    logic       rx_in, rx_s1_q, rx_s2_q, rx_prev_q;
    logic [3:0] rx_tcnt_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_sh_q;
    logic       rx_eight_q, rx_pen_q, rx_ohel_q, rx_pbit_q;

    assign rx_evt  = rx_st_q == StStop && tick && rx_tcnt_q == 4'd15;
    assign rx_push = rx_evt && !rx_full;
    assign rx_perr = rx_pen_q && (rx_pbit_q != (^rx_sh_q ^ rx_ohel_q));

`ifdef UART_LOOPBACK_EN
    assign rx_in = ie_q[3] ? tx_q : rx;
    assign tx    = ie_q[3] ? 1'b1 : tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TxAw-1:0]] <= wdata;
        if (rx_push) rx_mem[rx_wp_q[RxAw-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ie_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_load) tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            // A flag raised in the same cycle as a status read survives the clear
            ovf_q  <= (ovf_q && !stat_rd) || (rx_evt && rx_full);
            ferr_q <= (ferr_q && !stat_rd) || (rx_evt && !rx_s2_q);
            perr_q <= (perr_q && !stat_rd) || (rx_evt && rx_perr);
            if (wr_en && addr == 2'd1) ie_q <= wdata[IeW-1:0];
            irq_q <= (ie_q[0] && !rx_empty) || (ie_q[1] && tx_empty) ||
                     (ie_q[2] && (ovf_q || ferr_q || perr_q));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q    <= StIdle;
            tx_div_q   <= '0;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_eight_q <= 1'b1;
            tx_pen_q   <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_st_q)
                StStart:  tx_q <= 1'b0;
                StData:   tx_q <= tx_sh_q[0];
                StParity: tx_q <= tx_par_q;
                default:  tx_q <= 1'b1;
            endcase
            if (tx_load) begin
                tx_st_q    <= StStart;
                tx_div_q   <= '0;
                tx_tcnt_q  <= '0;
                tx_sh_q    <= tx_head;
                tx_eight_q <= eight;
                tx_pen_q   <= pen;
                tx_par_q   <= ^(tx_head & {eight, 7'h7f}) ^ ohel;
            end else if (tx_st_q != StIdle) begin
                if (tx_div_q >= baud_div) begin
                    tx_div_q  <= '0;
                    tx_tcnt_q <= tx_tcnt_q + 4'd1;
                end else begin
                    tx_div_q <= tx_div_q + 1'b1;
                end
                if (tx_bit_end) begin
                    case (tx_st_q)
                        StStart: begin
                            tx_st_q  <= StData;
                            tx_bit_q <= '0;
                        end
                        StData: begin
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_bit_q <= tx_bit_q + 3'd1;
                            if (tx_bit_q == (tx_eight_q ? 3'd7 : 3'd6)) begin
                                tx_st_q <= tx_pen_q ? StParity : StStop;
                            end
                        end
                        StParity: tx_st_q <= StStop;
                        default:  tx_st_q <= StIdle;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= StIdle;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_eight_q <= 1'b1;
            rx_pen_q   <= 1'b0;
            rx_ohel_q  <= 1'b0;
            rx_pbit_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_st_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_st_q    <= StStart;
                        rx_tcnt_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_sh_q    <= '0;
                        rx_eight_q <= eight;
                        rx_pen_q   <= pen;
                        rx_ohel_q  <= ohel;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_q <= '0;
                            rx_st_q   <= rx_s2_q ? StIdle : StData;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            case (rx_st_q)
                                StData: begin
                                    rx_sh_q[rx_bit_q] <= rx_s2_q;
                                    rx_bit_q <= rx_bit_q + 3'd1;
                                    if (rx_bit_q == (rx_eight_q ? 3'd7 : 3'd6)) begin
                                        rx_st_q <= rx_pen_q ? StParity : StStop;
                                    end
                                end
                                StParity: begin
                                    rx_pbit_q <= rx_s2_q;
                                    rx_st_q   <= StStop;
                                end
                                default: rx_st_q <= StIdle;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                2'd0: if (!rx_empty) rdata = rx_mem[rx_rp_q[RxAw-1:0]] & {eight, 7'h7f};
                2'd1: rdata = {2'b00, tx_idle, ovf_q, ferr_q, perr_q, !tx_full, !rx_empty};
                2'd2: rdata = 8'(ie_q);
                default: rdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule
